// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer -- multi-cycle IEEE-754 adder/subtractor, one operation in flight.
//
// Operands are taken in IDLE and walked through SWAP, ALIGN, ADD, NORM, ROUND and DONE.
// Subnormal inputs and results are flushed to zero. Rounding is round-to-nearest-even.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered          in_ready   high only in IDLE
//   op_a/op_b  IEEE-754 operands             sub        1 = A-B, 0 = A+B
//   out_valid  result held in DONE           out_ready  consumer takes result
//   result     rounded sum                   busy       high outside IDLE
module fp_add_sequencer #(
  parameter int SIG_BITS = 23,
  parameter int EXP_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_BITS+SIG_BITS:0]   op_a,
  input  logic [EXP_BITS+SIG_BITS:0]   op_b,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_BITS+SIG_BITS:0]   result,
  output logic                         busy
);

  localparam int W = 1 + EXP_BITS + SIG_BITS;
  localparam int M = SIG_BITS + 4;   // {hidden, frac, G, R, S}
  localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
  localparam logic [EXP_BITS:0]   EXP_ONE  = {{EXP_BITS{1'b0}}, 1'b1};
  localparam logic [EXP_BITS-1:0] D_MAX    = EXP_BITS'(M - 1);
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(SIG_BITS-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SWAP, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [W-1:0]        r_a, r_b, r_result;
  logic                r_sub, r_sign_x, r_sign_y, r_zero;
  logic [EXP_BITS:0]   r_exp;     // extra bit absorbs the carry into the all-ones exponent
  logic [EXP_BITS-1:0] r_exp_y;
  logic [M-1:0]        r_x, r_y;
  logic [M:0]          r_sum;

  // ---------------- SWAP: classify and order operands ----------------
  logic                w_sign_a, w_sign_b, w_b_larger;
  logic [EXP_BITS-1:0] w_exp_a, w_exp_b;
  logic [SIG_BITS-1:0] w_frac_a, w_frac_b;
  logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_special;
  logic [M-1:0]        w_sig_a, w_sig_b;
  logic [W-1:0]        w_special_res;

  assign w_sign_a   = r_a[W-1];
  assign w_sign_b   = r_b[W-1] ^ r_sub;
  assign w_exp_a    = r_a[W-2:SIG_BITS];
  assign w_exp_b    = r_b[W-2:SIG_BITS];
  assign w_frac_a   = r_a[SIG_BITS-1:0];
  assign w_frac_b   = r_b[SIG_BITS-1:0];
  // Strictly greater: equal magnitudes keep A as the larger operand.
  assign w_b_larger = r_b[W-2:0] > r_a[W-2:0];

  assign w_nan_a  = (w_exp_a == EXP_ONES) && (w_frac_a != '0);
  assign w_nan_b  = (w_exp_b == EXP_ONES) && (w_frac_b != '0);
  assign w_inf_a  = (w_exp_a == EXP_ONES) && (w_frac_a == '0);
  assign w_inf_b  = (w_exp_b == EXP_ONES) && (w_frac_b == '0);
  assign w_zero_a = (w_exp_a == '0);
  assign w_zero_b = (w_exp_b == '0);
  assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | (w_zero_a & w_zero_b);

  // Zero exponent flushes the fraction as well, so subnormals behave as zero.
  assign w_sig_a = w_zero_a ? '0 : {1'b1, w_frac_a, 3'b000};
  assign w_sig_b = w_zero_b ? '0 : {1'b1, w_frac_b, 3'b000};

  always_comb begin
    w_special_res = {w_sign_a & w_sign_b, {(W-1){1'b0}}};
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b)))
      w_special_res = QNAN;
    else if (w_inf_a)
      w_special_res = {w_sign_a, EXP_ONES, {SIG_BITS{1'b0}}};
    else if (w_inf_b)
      w_special_res = {w_sign_b, EXP_ONES, {SIG_BITS{1'b0}}};
  end

  // ---------------- ALIGN: sticky right shift of Y ----------------
  logic [EXP_BITS-1:0] w_d;
  logic [M-1:0]        w_mask, w_y_shr, w_y_aligned;

  assign w_d     = r_exp[EXP_BITS-1:0] - r_exp_y;
  assign w_mask  = ({{(M-1){1'b0}}, 1'b1} << w_d) - {{(M-1){1'b0}}, 1'b1};
  assign w_y_shr = r_y >> w_d;
  assign w_y_aligned = (w_d > D_MAX) ? {{(M-1){1'b0}}, |r_y}
                                     : (w_y_shr | {{(M-1){1'b0}}, |(r_y & w_mask)});

  // ---------------- ADD ----------------
  logic [M:0] w_sum;
  assign w_sum = (r_sign_x == r_sign_y) ? ({1'b0, r_x} + {1'b0, r_y})
                                        : ({1'b0, r_x} - {1'b0, r_y});

  // ---------------- NORM exit ----------------
  // Leave once the sum is zero, overflowed (one right shift), normalised, or
  // another left shift would drive the exponent to zero.
  logic w_norm_done;
  assign w_norm_done = (r_sum == '0) | r_sum[M] | r_sum[M-1] | (r_exp == EXP_ONE);

  // ---------------- ROUND ----------------
  logic                w_up;
  logic [SIG_BITS+1:0] w_mant_r;
  logic [EXP_BITS:0]   w_exp_r;
  logic [SIG_BITS-1:0] w_frac_r;
  logic [W-1:0]        w_round_res;

  assign w_up     = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_mant_r = {1'b0, r_sum[M-1:3]} + {{(SIG_BITS+1){1'b0}}, w_up};
  assign w_exp_r  = r_exp + {{EXP_BITS{1'b0}}, w_mant_r[SIG_BITS+1]};
  assign w_frac_r = w_mant_r[SIG_BITS+1] ? w_mant_r[SIG_BITS:1] : w_mant_r[SIG_BITS-1:0];

  always_comb begin
    w_round_res = {r_sign_x, w_exp_r[EXP_BITS-1:0], w_frac_r};
    if (r_zero)
      w_round_res = '0;
    else if (w_exp_r >= {1'b0, EXP_ONES})
      w_round_res = {r_sign_x, EXP_ONES, {SIG_BITS{1'b0}}};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = S_SWAP;
      end
      S_SWAP:  w_state_next = w_special ? S_DONE : S_ALIGN;
      S_ALIGN: w_state_next = S_ADD;
      S_ADD:   w_state_next = S_NORM;
      S_NORM:  if (w_norm_done) w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_sign_x <= 1'b0;
      r_sign_y <= 1'b0;
      r_exp    <= '0;
      r_exp_y  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_sum    <= '0;
      r_zero   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a   <= op_a;
          r_b   <= op_b;
          r_sub <= sub;
        end
        S_SWAP: begin
          if (w_b_larger) begin
            r_sign_x <= w_sign_b;  r_sign_y <= w_sign_a;
            r_exp    <= {1'b0, w_exp_b};  r_exp_y <= w_exp_a;
            r_x      <= w_sig_b;   r_y      <= w_sig_a;
          end else begin
            r_sign_x <= w_sign_a;  r_sign_y <= w_sign_b;
            r_exp    <= {1'b0, w_exp_a};  r_exp_y <= w_exp_b;
            r_x      <= w_sig_a;   r_y      <= w_sig_b;
          end
          if (w_special) r_result <= w_special_res;
        end
        S_ALIGN: r_y <= w_y_aligned;
        S_ADD: begin
          r_sum  <= w_sum;
          r_zero <= 1'b0;
        end
        S_NORM: begin
          if (r_sum == '0) begin
            r_zero <= 1'b1;
          end else if (r_sum[M]) begin
            r_sum <= {1'b0, r_sum[M:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EXP_ONE;
          end else if (!r_sum[M-1]) begin
            if (r_exp == EXP_ONE) begin
              r_zero <= 1'b1;
            end else begin
              r_sum <= {r_sum[M-1:0], 1'b0};
              r_exp <= r_exp - EXP_ONE;
            end
          end
        end
        S_ROUND: r_result <= w_round_res;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: expected results are queued when an operation is
// driven and popped when the block presents out_valid.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, busy;
  logic [31:0] op_a, op_b, result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] e;
  } vec_t;

  fp_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Offer one operand pair until accepted; inputs are scrambled afterwards so
  // any dependence on them while busy shows up as a wrong result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] expv, output bit ok);
    ok = 1'b0;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    exp_q.push_back(expv);
    for (int n = 0; n < 50 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
  endtask

  // Called in the cycle after accept (cycle 1); returns the cycle out_valid rose.
  task automatic wait_out(output logic [31:0] res, output int cyc, output bit ok);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok  = out_valid;
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h need 00000000", result); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    logic [31:0] r, e; int cyc; bit ok, got;
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept got no accept need accept"); end
    wait_out(r, cyc, got);
    e = exp_q.pop_front();
    $display("txn 3f800000 + 3f800000 -> %h cycles %0d", r, cyc);
    checks++; if (!got || r !== e) begin errors++; $display("FAIL add_result got %h need %h", r, e); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL add_latency got %0d need 6", cyc); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL add_release got out_valid %b in_ready %b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r, e; int cyc; bit ok, got;
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, ok);
    wait_out(r, cyc, got);
    e = exp_q.pop_front();
    $display("txn 3f800000 - 3f800000 -> %h cycles %0d", r, cyc);
    checks++; if (!ok || !got || r !== e) begin errors++; $display("FAIL cancel_result got %h need %h", r, e); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL cancel_latency got %0d need 6", cyc); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL cancel_done_busy got busy %b in_ready %b need 1 0", busy, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_fall got %b need 0", busy); end
  endtask

  task automatic test_sticky_tie();
    logic [31:0] r, e; int cyc; bit ok, got;
    out_ready = 1'b1;
    send(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, ok);
    wait_out(r, cyc, got);
    e = exp_q.pop_front();
    $display("txn 4b800000 + 3f800000 -> %h cycles %0d", r, cyc);
    checks++; if (!ok || !got || r !== e) begin errors++; $display("FAIL tie_even got %h need %h", r, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_specials();
    vec_t tbl[5];
    logic [31:0] r, e; int cyc; bit ok, got;
    tbl[0] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000};
    tbl[1] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000};
    tbl[2] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, ok);
      wait_out(r, cyc, got);
      e = exp_q.pop_front();
      $display("txn %h %s %h -> %h cycles %0d", tbl[i].a, tbl[i].s ? "-" : "+", tbl[i].b, r, cyc);
      checks++; if (!ok || !got || r !== e) begin errors++; $display("FAIL special_%0d got %h need %h", i, r, e); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL special_latency_%0d got %0d need 2", i, cyc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith();
    vec_t tbl[8];
    logic [31:0] r, e; int cyc; bit ok, got;
    tbl[0] = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000}; // 1.5 + 2.25
    tbl[1] = '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000}; // 1 - 0.5
    tbl[2] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000}; // -2 + 1
    tbl[3] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000}; // 1 - 2 (swap)
    tbl[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000}; // overflow
    tbl[5] = '{32'h4B800001, 32'h3F800000, 1'b0, 32'h4B800002}; // tie rounds up to even
    tbl[6] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000}; // underflow flush
    tbl[7] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000}; // subnormal input
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, ok);
      wait_out(r, cyc, got);
      e = exp_q.pop_front();
      $display("txn %h %s %h -> %h cycles %0d", tbl[i].a, tbl[i].s ? "-" : "+", tbl[i].b, r, cyc);
      checks++; if (!ok || !got || r !== e) begin errors++; $display("FAIL arith_%0d got %h need %h", i, r, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, e; int cyc; bit ok, got;
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, ok);
    wait_out(r, cyc, got);
    e = exp_q.pop_front();
    $display("txn 3f800000 + 40000000 -> %h cycles %0d (held)", r, cyc);
    checks++; if (!ok || !got || r !== e) begin errors++; $display("FAIL hold_result got %h need %h", r, e); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000; sub = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== e) begin
        errors++; $display("FAIL hold_stable_%0d got %b %h need 1 %h", i, out_valid, result, e);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_%0d got %b need 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got out_valid %b busy %b need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok, seen;
    out_ready = 1'b1;
    send(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, ok);
    // The operation is discarded by reset, so its expectation is dropped.
    void'(exp_q.pop_back());
    repeat (5) @(posedge clk); #1;   // cycle 6: NORM is still shifting
    checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b need 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async got in_ready %b out_valid %b busy %b need 1 0 0", in_ready, out_valid, busy);
    end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h need 00000000", result); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    $display("txn 3f800001 - 3f800000 -> discarded by reset");
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got activity %b need 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_cancel();
    test_sticky_tie();
    test_specials();
    test_arith();
    test_backpressure();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty got %0d need 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
